// File: rtl/wb_rr_arbiter3.sv
// wb_rr_arbiter3: three-master round-robin Wishbone arbiter with optional per-transfer bus watchdog
// Ports: wb_clk_i/wb_rst_ni (async active-low); wbm0..2_* master sides; wbs_* shared slave side;
//        grant_o index of the granted master (valid while busy_o); busy_o a tenure is active.
// Config: define WB_ARB_TIMEOUT_EN to build the watchdog with the ABORT/DRAIN states.
module wb_rr_arbiter3 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SELECT_WIDTH = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  input  logic                    wbm0_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  input  logic                    wbm0_cyc_i,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  input  logic                    wbm1_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  input  logic                    wbm1_cyc_i,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  input  logic [ADDR_WIDTH-1:0]   wbm2_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm2_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm2_dat_o,
  input  logic                    wbm2_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm2_sel_i,
  input  logic                    wbm2_stb_i,
  input  logic                    wbm2_cyc_i,
  output logic                    wbm2_ack_o,
  output logic                    wbm2_err_o,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  output logic [1:0]              grant_o,
  output logic                    busy_o
);
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_rr_arbiter3: TIMEOUT must be 1..65535");
  end
`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, GRANT, ABORT, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif
  state_t state, state_nx;
  logic [1:0] grant, last, n1, n2, pick;
  logic [ADDR_WIDTH-1:0] adr [3];
  logic [DATA_WIDTH-1:0] dat [3];
  logic [SELECT_WIDTH-1:0] sel [3];
  logic [2:0] we, stb, cyc, ack, err;
  logic timeout;
  assign adr = '{wbm0_adr_i, wbm1_adr_i, wbm2_adr_i};
  assign dat = '{wbm0_dat_i, wbm1_dat_i, wbm2_dat_i};
  assign sel = '{wbm0_sel_i, wbm1_sel_i, wbm2_sel_i};
  assign we = {wbm2_we_i, wbm1_we_i, wbm0_we_i};
  assign stb = {wbm2_stb_i, wbm1_stb_i, wbm0_stb_i};
  assign cyc = {wbm2_cyc_i, wbm1_cyc_i, wbm0_cyc_i};
  assign {wbm2_ack_o, wbm1_ack_o, wbm0_ack_o} = ack;
  assign {wbm2_err_o, wbm1_err_o, wbm0_err_o} = err;
  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign wbm2_dat_o = wbs_dat_i;
  assign grant_o = grant;
  assign busy_o = state != IDLE;
  // search order last+1, last+2, then last itself
  assign n1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
  assign n2 = (n1 == 2'd2) ? 2'd0 : n1 + 2'd1;
  assign pick = cyc[n1] ? n1 : cyc[n2] ? n2 : last;
`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wdt;
  logic stall;
  // an unanswered strobe in GRANT is the only thing that advances the watchdog
  assign stall = state == GRANT && stb[grant] && !wbs_ack_i && !wbs_err_i;
  assign timeout = stall && wdt == 16'(TIMEOUT - 1);
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) wdt <= '0;
    else wdt <= stall ? wdt + 16'd1 : '0;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    ack = '0;
    err = '0;
    unique case (state)
      IDLE: state_nx = |cyc ? GRANT : IDLE;
      GRANT: begin
        wbs_adr_o = adr[grant];
        wbs_dat_o = dat[grant];
        wbs_sel_o = sel[grant];
        wbs_we_o = we[grant];
        wbs_stb_o = stb[grant];
        wbs_cyc_o = cyc[grant];
        ack[grant] = wbs_ack_i;
        err[grant] = wbs_err_i;
`ifdef WB_ARB_TIMEOUT_EN
        // a master releasing cyc beats a coincident timeout
        state_nx = !cyc[grant] ? IDLE : timeout ? ABORT : GRANT;
`else
        state_nx = !cyc[grant] ? IDLE : timeout ? IDLE : GRANT;
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        err[grant] = 1'b1;
        state_nx = DRAIN;
      end
      DRAIN: state_nx = cyc[grant] ? DRAIN : IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state <= IDLE;
      grant <= 2'd0;
      last <= 2'd2;
    end else begin
      state <= state_nx;
      if (state == IDLE && |cyc) begin
        grant <= pick;
        last <= pick;
      end
    end
endmodule

// File: tb/tb_wb_rr_arbiter3.sv
// tb_wb_rr_arbiter3: directed vector bench for wb_rr_arbiter3
module tb_wb_rr_arbiter3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] cyc = '0, stb = '0;
  logic ack_i = 1'b0, err_i = 1'b0;
  logic [31:0] wbs_dat_i = 32'h5A5A_C3C3;
  logic [31:0] adr_c [3];
  logic [31:0] dat_c [3];
  logic [3:0] sel_c [3];
  logic [2:0] we_c = 3'b010;
  wire [2:0] acko, erro;
  wire [31:0] d0, d1, d2, wbs_adr_o, wbs_dat_o;
  wire [3:0] wbs_sel_o;
  wire wbs_we_o, wbs_stb_o, wbs_cyc_o, busy_o;
  wire [1:0] grant_o;
  int vecs = 0, errs = 0;
  typedef struct {
    logic [2:0] cyc, stb;
    logic ack, err, busy;
    logic [1:0] g;
    logic wc, ws;
    logic [2:0] ea, ee;
    logic mux;
  } vec_t;
  vec_t tbl [$];
  always #5 clk = ~clk;
  initial begin
    adr_c = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
    dat_c = '{32'hD000_0010, 32'hD000_0011, 32'hD000_0012};
    sel_c = '{4'h1, 4'h3, 4'hF};
  end
  wb_rr_arbiter3 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm0_adr_i(adr_c[0]), .wbm0_dat_i(dat_c[0]), .wbm0_dat_o(d0), .wbm0_we_i(we_c[0]),
    .wbm0_sel_i(sel_c[0]), .wbm0_stb_i(stb[0]), .wbm0_cyc_i(cyc[0]), .wbm0_ack_o(acko[0]), .wbm0_err_o(erro[0]),
    .wbm1_adr_i(adr_c[1]), .wbm1_dat_i(dat_c[1]), .wbm1_dat_o(d1), .wbm1_we_i(we_c[1]),
    .wbm1_sel_i(sel_c[1]), .wbm1_stb_i(stb[1]), .wbm1_cyc_i(cyc[1]), .wbm1_ack_o(acko[1]), .wbm1_err_o(erro[1]),
    .wbm2_adr_i(adr_c[2]), .wbm2_dat_i(dat_c[2]), .wbm2_dat_o(d2), .wbm2_we_i(we_c[2]),
    .wbm2_sel_i(sel_c[2]), .wbm2_stb_i(stb[2]), .wbm2_cyc_i(cyc[2]), .wbm2_ack_o(acko[2]), .wbm2_err_o(erro[2]),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o),
    .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o), .wbs_dat_i(wbs_dat_i), .wbs_ack_i(ack_i),
    .wbs_err_i(err_i), .grant_o(grant_o), .busy_o(busy_o)
  );
  function automatic logic [127:0] act_sig();
    return 128'({busy_o, grant_o, wbs_cyc_o, wbs_stb_o, acko, erro, wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o});
  endfunction
  function automatic logic [127:0] exp_sig(input logic busy, input logic [1:0] g, input logic wc, ws,
                                           input logic [2:0] ea, ee, input logic mux);
    return 128'({busy, g, wc, ws, ea, ee, mux ? adr_c[g] : 32'h0, mux ? dat_c[g] : 32'h0,
                 mux ? sel_c[g] : 4'h0, mux ? we_c[g] : 1'b0});
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] c, input logic [2:0] s, input logic a, input logic e);
    cyc = c;
    stb = s;
    ack_i = a;
    err_i = e;
    #1;
  endtask
  task automatic row(input logic [2:0] c, s, input logic a, e, busy, input logic [1:0] g,
                     input logic wc, ws, input logic [2:0] ea, ee, input logic mux);
    tbl.push_back('{cyc: c, stb: s, ack: a, err: e, busy: busy, g: g, wc: wc, ws: ws, ea: ea, ee: ee, mux: mux});
  endtask
  initial begin
    row(3'b011, 3'b011, 0, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000, 0);
    row(3'b011, 3'b011, 1, 0, 1, 2'd0, 1, 1, 3'b001, 3'b000, 1);
    row(3'b010, 3'b010, 0, 0, 1, 2'd0, 0, 0, 3'b000, 3'b000, 1);
    row(3'b010, 3'b010, 0, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000, 0);
    row(3'b010, 3'b010, 1, 0, 1, 2'd1, 1, 1, 3'b010, 3'b000, 1);
    row(3'b000, 3'b000, 0, 0, 1, 2'd1, 0, 0, 3'b000, 3'b000, 1);
    row(3'b000, 3'b000, 0, 0, 0, 2'd1, 0, 0, 3'b000, 3'b000, 0);
    row(3'b111, 3'b111, 0, 0, 0, 2'd1, 0, 0, 3'b000, 3'b000, 0);
    row(3'b111, 3'b111, 1, 0, 1, 2'd2, 1, 1, 3'b100, 3'b000, 1);
    row(3'b011, 3'b011, 0, 0, 1, 2'd2, 0, 0, 3'b000, 3'b000, 1);
    row(3'b111, 3'b111, 0, 0, 0, 2'd2, 0, 0, 3'b000, 3'b000, 0);
    row(3'b111, 3'b111, 1, 0, 1, 2'd0, 1, 1, 3'b001, 3'b000, 1);
    row(3'b110, 3'b110, 0, 0, 1, 2'd0, 0, 0, 3'b000, 3'b000, 1);
    row(3'b111, 3'b111, 0, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000, 0);
    row(3'b111, 3'b111, 1, 0, 1, 2'd1, 1, 1, 3'b010, 3'b000, 1);
    row(3'b101, 3'b101, 0, 0, 1, 2'd1, 0, 0, 3'b000, 3'b000, 1);
    row(3'b111, 3'b111, 0, 0, 0, 2'd1, 0, 0, 3'b000, 3'b000, 0);
    row(3'b111, 3'b111, 1, 0, 1, 2'd2, 1, 1, 3'b100, 3'b000, 1);
    row(3'b011, 3'b011, 0, 0, 1, 2'd2, 0, 0, 3'b000, 3'b000, 1);
    row(3'b111, 3'b111, 0, 0, 0, 2'd2, 0, 0, 3'b000, 3'b000, 0);
    row(3'b111, 3'b111, 0, 1, 1, 2'd0, 1, 1, 3'b000, 3'b001, 1);
    row(3'b110, 3'b110, 0, 0, 1, 2'd0, 0, 0, 3'b000, 3'b000, 1);
    row(3'b000, 3'b000, 0, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000, 0);
    row(3'b110, 3'b110, 0, 0, 0, 2'd0, 0, 0, 3'b000, 3'b000, 0);
    for (int i = 0; i < 4; i++) row(3'b110, 3'b110, 1, 0, 1, 2'd1, 1, 1, 3'b010, 3'b000, 1);
    row(3'b110, 3'b110, 0, 0, 1, 2'd1, 1, 1, 3'b000, 3'b000, 1);
    row(3'b100, 3'b100, 0, 0, 1, 2'd1, 0, 0, 3'b000, 3'b000, 1);
    row(3'b100, 3'b100, 0, 0, 0, 2'd1, 0, 0, 3'b000, 3'b000, 0);
    row(3'b100, 3'b000, 0, 0, 1, 2'd2, 1, 0, 3'b000, 3'b000, 1);
    row(3'b000, 3'b000, 0, 0, 1, 2'd2, 0, 0, 3'b000, 3'b000, 1);
    row(3'b000, 3'b000, 0, 0, 0, 2'd2, 0, 0, 3'b000, 3'b000, 0);
    step();
    step();
    chk("reset_state", act_sig(), 128'h0);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cyc, tbl[i].stb, tbl[i].ack, tbl[i].err);
      chk($sformatf("row%0d", i), act_sig(),
          exp_sig(tbl[i].busy, tbl[i].g, tbl[i].wc, tbl[i].ws, tbl[i].ea, tbl[i].ee, tbl[i].mux));
      step();
    end
    chk("dat_broadcast", 128'({d0, d1, d2}), 128'({3{32'h5A5A_C3C3}}));
    // stalled slave on master 0 (last = 2 so m0 wins)
    drive(3'b001, 3'b001, 0, 0);
    chk("wd_idle", 128'(busy_o), 128'(0));
    step();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("wd_stall%0d", k), 128'({busy_o, wbs_cyc_o, acko, erro}), 128'({2'b11, 6'b0}));
      step();
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("wd_abort", 128'({busy_o, wbs_cyc_o, wbs_stb_o, acko, erro}), 128'({3'b100, 3'b000, 3'b001}));
    step();
    drive(3'b001, 3'b001, 1, 0);
    chk("wd_drain", 128'({busy_o, wbs_cyc_o, acko, erro}), 128'({2'b10, 6'b0}));
    step();
    drive(3'b000, 3'b000, 0, 0);
    chk("wd_drain_exit", 128'(busy_o), 128'(1));
    step();
    chk("wd_idle_after", 128'(busy_o), 128'(0));
`else
    chk("stall_hold", 128'({busy_o, wbs_cyc_o, erro}), 128'({2'b11, 3'b000}));
    drive(3'b001, 3'b001, 0, 1);
    chk("err_pass", 128'(erro), 128'(3'b001));
    step();
    drive(3'b000, 3'b000, 0, 0);
    step();
    chk("stall_release", 128'(busy_o), 128'(0));
`endif
    // ack on the 8th stalled cycle wins, and the watchdog restarts from zero
    drive(3'b001, 3'b001, 0, 0);
    chk("ack8_idle", 128'({busy_o, grant_o}), 128'(3'b000));
    step();
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("ack8_wait%0d", k), 128'({busy_o, wbs_cyc_o, acko, erro}), 128'({2'b11, 6'b0}));
      step();
    end
    drive(3'b001, 3'b001, 1, 0);
    chk("ack8_ack", 128'({busy_o, wbs_cyc_o, acko, erro}), 128'({2'b11, 3'b001, 3'b000}));
    step();
    drive(3'b001, 3'b001, 0, 0);
    for (int k = 9; k <= 16; k++) begin
      chk($sformatf("ack8_restart%0d", k), 128'({busy_o, wbs_cyc_o, acko, erro}), 128'({2'b11, 6'b0}));
      step();
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("ack8_late_abort", 128'({busy_o, wbs_cyc_o, acko, erro}), 128'({2'b10, 3'b000, 3'b001}));
`else
    chk("ack8_no_abort", 128'({busy_o, wbs_cyc_o, acko, erro}), 128'({2'b11, 6'b0}));
`endif
    drive(3'b000, 3'b000, 0, 0);
    step();
    step();
    step();
    chk("ack8_end", 128'(busy_o), 128'(0));
    // cyc released in the same cycle the watchdog expires: no err
    drive(3'b001, 3'b001, 0, 0);
    step();
    for (int k = 1; k <= 7; k++) step();
    drive(3'b000, 3'b001, 0, 0);
    chk("drop_at_timeout", 128'({busy_o, wbs_cyc_o, erro}), 128'({2'b10, 3'b000}));
    step();
    drive(3'b000, 3'b000, 0, 0);
    chk("drop_idle", 128'({busy_o, erro}), 128'(0));
    // asynchronous reset in the middle of a granted transfer
    drive(3'b111, 3'b111, 0, 0);
    step();
    drive(3'b111, 3'b111, 1, 0);
    chk("pre_reset", 128'({busy_o, grant_o, acko}), 128'({1'b1, 2'd1, 3'b010}));
    rst_n = 1'b0;
    #1;
    chk("async_reset", act_sig(), 128'h0);
    @(posedge clk);
    #3;
    chk("reset_held", act_sig(), 128'h0);
    rst_n = 1'b1;
    drive(3'b111, 3'b111, 0, 0);
    step();
    chk("after_reset_m0", act_sig(), exp_sig(1, 2'd0, 1, 1, 3'b000, 3'b000, 1));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
